// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports (CPU MEM stage and DMA/debug)
// plus the data-memory side. The slave modport is the arbiter's view.
interface dm_arbiter_if;
   // Port 0: CPU memory stage
   logic        m0_req;
   logic        m0_we;
   logic [3:0]  m0_be;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic [31:0] m0_pc;
   logic        m0_lock;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m0_err;

   // Port 1: DMA / debug requester
   logic        m1_req;
   logic        m1_we;
   logic [3:0]  m1_be;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;
   logic        m1_err;

   // Data memory side
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [3:0]  dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_rdata;

   modport slave (
      input  m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc, m0_lock,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output dm_addr, dm_wd, dm_we, dm_pc,
      input  dm_rdata
   );

   modport master (
      output m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc, m0_lock,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  dm_addr, dm_wd, dm_we, dm_pc,
      output dm_rdata
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 may lock the grant for up to MAX_LOCK extra cycles (atomic RMW).
// Addresses are range-checked; each accepted access gets a registered
// response (rvalid/rdata/err) one cycle later.
module dm_arbiter #(
   parameter int DM_BYTES = 12288,
   parameter int MAX_LOCK = 4
) (
   input  logic         clk,
   input  logic         reset,
   dm_arbiter_if.slave  bus
);
   localparam int              CNT_W      = $clog2(MAX_LOCK + 1);
   localparam logic [31:0]     ADDR_LIMIT = 32'(DM_BYTES);
   localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(MAX_LOCK);

   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

   port_e             r_last_grant;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic              r_m0_rvalid, r_m0_err;
   logic              r_m1_rvalid, r_m1_err;
   logic [31:0]       r_m0_rdata, r_m1_rdata;

   logic w_lock_active;
   logic w_in0, w_in1;
   logic w_err0, w_err1;
   logic w_gnt0, w_gnt1;

   // A non-zero lock count means port 0 owns the grant this cycle if it asks.
   assign w_lock_active = (r_lock_cnt != '0);

   assign w_in0  = (bus.m0_addr < ADDR_LIMIT);
   assign w_in1  = (bus.m1_addr < ADDR_LIMIT);
   assign w_err0 = !w_in0 || (bus.m0_we && (bus.m0_be == 4'b0000));
   assign w_err1 = !w_in1 || (bus.m1_we && (bus.m1_be == 4'b0000));

   // Port 0 wins when locked, uncontested, or port 1 was granted last.
   assign w_gnt0 = !reset && bus.m0_req &&
                   (w_lock_active || !bus.m1_req || (r_last_grant == PORT1));
   assign w_gnt1 = !reset && bus.m1_req && !w_gnt0;

   assign bus.m0_gnt    = w_gnt0;
   assign bus.m1_gnt    = w_gnt1;
   assign bus.m0_rvalid = r_m0_rvalid;
   assign bus.m0_rdata  = r_m0_rdata;
   assign bus.m0_err    = r_m0_err;
   assign bus.m1_rvalid = r_m1_rvalid;
   assign bus.m1_rdata  = r_m1_rdata;
   assign bus.m1_err    = r_m1_err;

   // Route the granted port onto the DM; writes only when in range.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      bus.dm_addr = '0;
      bus.dm_wd   = '0;
      bus.dm_pc   = '0;
      bus.dm_we   = '0;
      if (w_gnt0) begin
         bus.dm_addr = bus.m0_addr;
         bus.dm_wd   = bus.m0_wdata;
         bus.dm_pc   = bus.m0_pc;
         if (bus.m0_we && w_in0) bus.dm_we = bus.m0_be;
      end else if (w_gnt1) begin
         bus.dm_addr = bus.m1_addr;
         bus.dm_wd   = bus.m1_wdata;
         if (bus.m1_we && w_in1) bus.dm_we = bus.m1_be;
      end
   end

   // Round-robin pointer and bounded lock counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_last_grant <= PORT1;
         r_lock_cnt   <= '0;
      end else begin
         if (w_gnt0)      r_last_grant <= PORT0;
         else if (w_gnt1) r_last_grant <= PORT1;

         // At the cap the lock request is ignored and the count restarts.
         if (w_gnt0 && bus.m0_lock)
            r_lock_cnt <= (r_lock_cnt == LOCK_MAX) ? '0 : r_lock_cnt + CNT_W'(1);
         else
            r_lock_cnt <= '0;
      end
   end

   // Register the one-cycle response for whichever port was accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_m0_rvalid <= 1'b0;
         r_m0_err    <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rvalid <= 1'b0;
         r_m1_err    <= 1'b0;
         r_m1_rdata  <= '0;
      end else begin
         r_m0_rvalid <= w_gnt0;
         r_m0_err    <= w_gnt0 && w_err0;
         r_m0_rdata  <= (w_gnt0 && !bus.m0_we && w_in0) ? bus.dm_rdata : '0;
         r_m1_rvalid <= w_gnt1;
         r_m1_err    <= w_gnt1 && w_err1;
         r_m1_rdata  <= (w_gnt1 && !bus.m1_we && w_in1) ? bus.dm_rdata : '0;
      end
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a DM model, a cycle-level reference model with one
// compare process, and directed stimulus with hand-computed expectations.
module tb_dm_arbiter;
   localparam int DM_BYTES = 12288;
   localparam int MAX_LOCK = 4;
   localparam int WORDS    = DM_BYTES / 4;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   dm_arbiter_if bus ();

   dm_arbiter #(.DM_BYTES(DM_BYTES), .MAX_LOCK(MAX_LOCK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- data memory model (combinational read) ----------------
   logic [31:0] dm_mem [WORDS];

   assign bus.dm_rdata = (bus.dm_addr < 32'(DM_BYTES)) ? dm_mem[bus.dm_addr[13:2]] : 32'h0;

   initial begin
      for (int i = 0; i < WORDS; i++) dm_mem[i] = 32'h0;
      dm_mem[4]    = 32'hDEADBEEF;
      dm_mem[5]    = 32'hCAFEF00D;
      dm_mem[3071] = 32'h0BADF00D;
      forever begin
         @(posedge clk);
         for (int b = 0; b < 4; b++)
            if (bus.dm_we[b] && bus.dm_addr < 32'(DM_BYTES))
               dm_mem[bus.dm_addr[13:2]][8*b +: 8] <= bus.dm_wd[8*b +: 8];
      end
   end

   // ---------------- reference model + compare process ----------------
   logic [31:0] ref_mem [WORDS];
   int          m_last;      // port granted most recently
   int          m_run;       // consecutive accepted locked port-0 requests
   logic        m_v0, m_v1, m_e0, m_e1;
   logic [31:0] m_d0, m_d1;
   logic        m_g0, m_g1, m_hold, m_in, m_we, m_err;
   logic [3:0]  m_be, m_dmwe;
   logic [31:0] m_addr, m_wd, m_pc, m_rd;

   initial begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
      ref_mem[4]    = 32'hDEADBEEF;
      ref_mem[5]    = 32'hCAFEF00D;
      ref_mem[3071] = 32'h0BADF00D;
      m_last = 1; m_run = 0; m_v0 = 0; m_v1 = 0;
      m_e0 = 0; m_e1 = 0; m_d0 = 0; m_d1 = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst m0_gnt", bus.m0_gnt, 0);
            check("rst m1_gnt", bus.m1_gnt, 0);
            check("rst m0_rvalid", bus.m0_rvalid, 0);
            check("rst m1_rvalid", bus.m1_rvalid, 0);
            check("rst m0_rdata", bus.m0_rdata, 0);
            check("rst m0_err", bus.m0_err, 0);
            check("rst m1_err", bus.m1_err, 0);
            check("rst dm_we", bus.dm_we, 0);
            m_last = 1; m_run = 0; m_v0 = 0; m_v1 = 0;
         end else begin
            // Responses owed from the previous cycle's accept.
            check("mdl m0_rvalid", bus.m0_rvalid, m_v0);
            check("mdl m1_rvalid", bus.m1_rvalid, m_v1);
            if (m_v0) begin
               check("mdl m0_rdata", bus.m0_rdata, m_d0);
               check("mdl m0_err", bus.m0_err, m_e0);
            end
            if (m_v1) begin
               check("mdl m1_rdata", bus.m1_rdata, m_d1);
               check("mdl m1_err", bus.m1_err, m_e1);
            end

            // Who deserves the memory this cycle.
            m_hold = (m_run % (MAX_LOCK + 1)) != 0;
            m_g0 = 0; m_g1 = 0;
            if (bus.m0_req && bus.m1_req) begin
               if (m_hold || m_last == 1) m_g0 = 1;
               else                       m_g1 = 1;
            end else if (bus.m0_req) m_g0 = 1;
            else if (bus.m1_req)     m_g1 = 1;
            check("mdl m0_gnt", bus.m0_gnt, m_g0);
            check("mdl m1_gnt", bus.m1_gnt, m_g1);

            // Expected DM drive.
            m_addr = 0; m_wd = 0; m_pc = 0; m_we = 0; m_be = 0;
            if (m_g0) begin
               m_addr = bus.m0_addr; m_wd = bus.m0_wdata; m_pc = bus.m0_pc;
               m_we = bus.m0_we; m_be = bus.m0_be;
            end else if (m_g1) begin
               m_addr = bus.m1_addr; m_wd = bus.m1_wdata;
               m_we = bus.m1_we; m_be = bus.m1_be;
            end
            m_in   = m_addr < 32'(DM_BYTES);
            m_dmwe = ((m_g0 || m_g1) && m_we && m_in) ? m_be : 4'b0000;
            check("mdl dm_addr", bus.dm_addr, m_addr);
            check("mdl dm_wd", bus.dm_wd, m_wd);
            check("mdl dm_pc", bus.dm_pc, m_pc);
            check("mdl dm_we", bus.dm_we, m_dmwe);

            // Response for next cycle and memory side effect.
            m_err = !m_in || (m_we && m_be == 4'b0000);
            m_rd  = (!m_we && m_in) ? ref_mem[m_addr[13:2]] : 32'h0;
            m_v0 = m_g0; m_v1 = m_g1;
            if (m_g0) begin m_d0 = m_rd; m_e0 = m_err; end
            if (m_g1) begin m_d1 = m_rd; m_e1 = m_err; end
            for (int b = 0; b < 4; b++)
               if (m_dmwe[b]) ref_mem[m_addr[13:2]][8*b +: 8] = m_wd[8*b +: 8];

            if (m_g0)      m_last = 0;
            else if (m_g1) m_last = 1;
            m_run = (m_g0 && bus.m0_lock) ? m_run + 1 : 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input logic lock);
      bus.m0_req = req; bus.m0_we = we; bus.m0_be = be; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_pc = pc; bus.m0_lock = lock;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      bus.m1_req = req; bus.m1_we = we; bus.m1_be = be; bus.m1_addr = addr;
      bus.m1_wdata = wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   logic [5:0] alt_pat;

   initial begin
      reset = 1'b1;
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);
      set_m1(1, 0, 4'h0, 32'h14, 32'h0);
      sample();
      check("lit rst blocks m0_gnt", bus.m0_gnt, 0);
      check("lit rst blocks m1_gnt", bus.m1_gnt, 0);
      tick();
      reset = 1'b0;
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);

      // Single m0 read of a preloaded word.
      tick();
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h400, 0);
      sample();
      check("lit t1 m0_gnt", bus.m0_gnt, 1);
      check("lit t1 dm_pc", bus.dm_pc, 32'h400);
      tick();
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      sample();
      check("lit t1 m0_rvalid", bus.m0_rvalid, 1);
      check("lit t1 m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
      check("lit t1 m1_rvalid", bus.m1_rvalid, 0);

      // Continuous contention alternates; m0 won last so m1 goes first.
      alt_pat = 6'b010101;   // bit i = 1 -> m1 wins cycle i
      tick();
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);
      set_m1(1, 0, 4'h0, 32'h14, 32'h0);
      for (int i = 0; i < 6; i++) begin
         sample();
         check("lit alt m1_gnt", bus.m1_gnt, alt_pat[i]);
         check("lit alt m0_gnt", bus.m0_gnt, !alt_pat[i]);
         if (i > 0) begin
            check("lit alt m1_rvalid", bus.m1_rvalid, alt_pat[i-1]);
            check("lit alt m0_rvalid", bus.m0_rvalid, !alt_pat[i-1]);
         end
         tick();
      end
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);

      // Partial write by m0, then m1 reads the same word next cycle.
      tick();
      set_m0(1, 1, 4'b0011, 32'h20, 32'h12345678, 32'h404, 0);
      sample();
      check("lit wr dm_we", bus.dm_we, 4'b0011);
      tick();
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      set_m1(1, 0, 4'h0, 32'h20, 32'h0);
      sample();
      check("lit wr m0_rvalid", bus.m0_rvalid, 1);
      check("lit wr m0_err", bus.m0_err, 0);
      check("lit rd m1_gnt", bus.m1_gnt, 1);
      tick();
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);
      sample();
      check("lit rd m1_rdata", bus.m1_rdata, 32'h00005678);

      // Write with no byte enables is an error.
      tick();
      set_m0(1, 1, 4'b0000, 32'h24, 32'hFFFFFFFF, 32'h408, 0);
      sample();
      check("lit be0 dm_we", bus.dm_we, 4'b0000);
      tick();
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      sample();
      check("lit be0 m0_err", bus.m0_err, 1);

      // Write at exactly DM_BYTES is out of range.
      tick();
      set_m1(1, 1, 4'b1111, 32'h3000, 32'hA5A5A5A5);
      sample();
      check("lit oob m1_gnt", bus.m1_gnt, 1);
      check("lit oob dm_we", bus.dm_we, 4'b0000);
      tick();
      set_m1(1, 0, 4'h0, 32'h2FFC, 32'h0);
      sample();
      check("lit oob m1_rvalid", bus.m1_rvalid, 1);
      check("lit oob m1_err", bus.m1_err, 1);
      tick();
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);
      sample();
      check("lit top m1_rdata", bus.m1_rdata, 32'h0BADF00D);
      check("lit top m1_err", bus.m1_err, 0);

      // m0 locked against a waiting m1: five m0 grants, then m1.
      tick();
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h40C, 1);
      set_m1(1, 0, 4'h0, 32'h14, 32'h0);
      for (int i = 0; i < 6; i++) begin
         sample();
         check("lit lock m0_gnt", bus.m0_gnt, (i < 5) ? 1'b1 : 1'b0);
         check("lit lock m1_gnt", bus.m1_gnt, (i == 5) ? 1'b1 : 1'b0);
         tick();
      end
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);

      // Reset right after an accepted read drops its response.
      tick();
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h410, 0);
      sample();
      check("lit rr m0_gnt", bus.m0_gnt, 1);
      tick();
      reset = 1'b1;
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      sample();
      check("lit rr m0_rvalid", bus.m0_rvalid, 0);
      tick();
      tick();
      reset = 1'b0;
      sample();
      check("lit post m0_rvalid", bus.m0_rvalid, 0);
      check("lit post m1_rvalid", bus.m1_rvalid, 0);
      tick();
      set_m0(1, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);
      set_m1(1, 0, 4'h0, 32'h14, 32'h0);
      sample();
      check("lit post m0_gnt", bus.m0_gnt, 1);
      check("lit post m1_gnt", bus.m1_gnt, 0);
      tick();
      set_m0(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
      set_m1(0, 0, 4'h0, 32'h0, 32'h0);
      sample();
      check("lit post m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
